// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares the single VRAM port among NUM_REQ masters (0 = display refill,
//   1 = fragment shader, 2 = host/cmd). Master 0 has priority, but once it
//   has taken PRIO_BURST grants in a row while others wait, one of the other
//   masters is served. Masters 1..NUM_REQ-1 rotate round-robin.
//
// Ports
//   clk, reset_n_i        clock, synchronous active-low reset
//   req_sel_i/wr/addr/data/mask  per-master request bundle (packed, master k
//                         at slice k); sel is held until the master's ack
//   req_ack_o             one-cycle ack to the granted master only
//   req_data_o            read data broadcast (passthrough of vram_data_in_i)
//   grant_o               one-hot owner of the current transaction
//   busy_o                high while a transaction is in GRANT/RELEASE
//   vram_sel_o/wr/addr/data_out/mask  registered downstream request
//   vram_ack_i, vram_data_in_i        downstream ack and read data
module vram_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 16,
  parameter int PRIO_BURST = 4
) (
  input  logic                      clk,
  input  logic                      reset_n_i,
  input  logic [NUM_REQ-1:0]        req_sel_i,
  input  logic [NUM_REQ-1:0]        req_wr_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ*4-1:0]      req_mask_i,
  output logic [NUM_REQ-1:0]        req_ack_o,
  output logic [DATA_W-1:0]         req_data_o,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      busy_o,
  output logic                      vram_sel_o,
  output logic                      vram_wr_o,
  output logic [ADDR_W-1:0]         vram_addr_o,
  output logic [DATA_W-1:0]         vram_data_out_o,
  output logic [3:0]                vram_mask_o,
  input  logic                      vram_ack_i,
  input  logic [DATA_W-1:0]         vram_data_in_i
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int BC_W  = $clog2(PRIO_BURST + 1);

  localparam logic [IDX_W-1:0] RR_FIRST  = IDX_W'(1);
  localparam logic [IDX_W-1:0] RR_LAST   = IDX_W'(NUM_REQ - 1);
  localparam logic [BC_W-1:0]  BURST_MAX = BC_W'(PRIO_BURST);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t              state, next_state;
  logic [IDX_W-1:0]    rr_ptr, next_rr_ptr;
  logic [BC_W-1:0]     burst_cnt, next_burst_cnt;
  logic                abort_q, next_abort;
  logic                next_sel, next_wr, next_busy;
  logic [ADDR_W-1:0]   next_addr;
  logic [DATA_W-1:0]   next_data;
  logic [3:0]          next_mask;
  logic [NUM_REQ-1:0]  next_grant;

  // Round-robin search among masters 1..NUM_REQ-1 starting at rr_ptr
  logic                rr_found;
  logic [NUM_REQ-1:0]  rr_oh;
  logic [IDX_W-1:0]    rr_win;
  logic                other_pend;
  logic [NUM_REQ-1:0]  win_oh;

  always_comb begin
    int unsigned ptr32;
    int unsigned idx;
    ptr32    = 32'(rr_ptr);
    idx      = 0;
    rr_found = 1'b0;
    rr_oh    = '0;
    rr_win   = rr_ptr;
    for (int unsigned i = 0; i < NUM_REQ - 1; i++) begin
      idx = ((ptr32 - 1 + i) % (NUM_REQ - 1)) + 1;
      if (!rr_found && req_sel_i[idx]) begin
        rr_found   = 1'b1;
        rr_oh[idx] = 1'b1;
        rr_win     = idx[IDX_W-1:0];
      end
    end
  end

  assign other_pend = |req_sel_i[NUM_REQ-1:1];

  always_comb begin
    next_state     = state;
    next_rr_ptr    = rr_ptr;
    next_burst_cnt = burst_cnt;
    next_abort     = abort_q;
    next_sel       = vram_sel_o;
    next_wr        = vram_wr_o;
    next_addr      = vram_addr_o;
    next_data      = vram_data_out_o;
    next_mask      = vram_mask_o;
    next_grant     = grant_o;
    win_oh         = '0;

    unique case (state)
      IDLE: begin
        if (req_sel_i == '0) begin
          next_burst_cnt = '0;
        end else begin
          if (req_sel_i[0] && (burst_cnt < BURST_MAX || !other_pend)) begin
            win_oh[0] = 1'b1;
            // Saturate: with no competition master 0 may run indefinitely
            if (burst_cnt < BURST_MAX) next_burst_cnt = burst_cnt + BC_W'(1);
          end else begin
            win_oh         = rr_oh;
            next_rr_ptr    = (rr_win == RR_LAST) ? RR_FIRST : rr_win + IDX_W'(1);
            next_burst_cnt = '0;
          end
          for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (win_oh[k]) begin
              next_wr   = req_wr_i[k];
              next_addr = req_addr_i[k*ADDR_W +: ADDR_W];
              next_data = req_data_i[k*DATA_W +: DATA_W];
              next_mask = req_mask_i[k*4 +: 4];
            end
          end
          next_sel   = 1'b1;
          next_grant = win_oh;
          next_abort = 1'b0;
          next_state = GRANT;
        end
      end

      GRANT: begin
        // Owner dropped its request: let the access finish but withhold its ack
        if ((req_sel_i & grant_o) == '0) next_abort = 1'b1;
        if (vram_ack_i) begin
          next_sel   = 1'b0;
          next_wr    = 1'b0;
          next_state = RELEASE;
        end
      end

      RELEASE: begin
        next_grant = '0;
        next_abort = 1'b0;
        next_state = IDLE;
      end

      default: begin
        next_sel   = 1'b0;
        next_wr    = 1'b0;
        next_grant = '0;
        next_state = IDLE;
      end
    endcase

    next_busy = (next_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      state           <= IDLE;
      rr_ptr          <= RR_FIRST;
      burst_cnt       <= '0;
      abort_q         <= 1'b0;
      vram_sel_o      <= 1'b0;
      vram_wr_o       <= 1'b0;
      vram_addr_o     <= '0;
      vram_data_out_o <= '0;
      vram_mask_o     <= '1;
      grant_o         <= '0;
      busy_o          <= 1'b0;
    end else begin
      state           <= next_state;
      rr_ptr          <= next_rr_ptr;
      burst_cnt       <= next_burst_cnt;
      abort_q         <= next_abort;
      vram_sel_o      <= next_sel;
      vram_wr_o       <= next_wr;
      vram_addr_o     <= next_addr;
      vram_data_out_o <= next_data;
      vram_mask_o     <= next_mask;
      grant_o         <= next_grant;
      busy_o          <= next_busy;
    end
  end

  // The abort flag is registered, so also gate with the live request to
  // cover a master dropping sel in the very cycle the ack arrives.
  assign req_ack_o  = (state == GRANT && vram_ack_i && !abort_q) ? (grant_o & req_sel_i) : '0;
  assign req_data_o = vram_data_in_i;

endmodule
